fork_join_ctrl: RTL and testbench

//  Hardware fork/join scheduler for a bank of N parallel job engines.
//  A start launches a masked group of jobs and waits per join mode: ALL, ANY or NONE.
//  In ANY mode it can abort the remaining jobs of the group ("disable fork").
//  A watchdog aborts the group on timeout; jobs left running under NONE stay tracked.

---
 rtl/fork_join_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_fork_join_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fork_join_ctrl.sv
// Fork/join scheduler for a bank of parallel job engines: launches a masked group,
// then resolves it as JOIN_ALL, JOIN_ANY (optionally aborting the rest) or JOIN_NONE.
module fork_join_ctrl #(
    parameter  int unsigned N_JOBS = 4,
    parameter  int unsigned TMO_W  = 16,
    localparam int unsigned ID_W   = $clog2(N_JOBS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              kill_rest,
    input  logic [N_JOBS-1:0] job_mask,
    input  logic [TMO_W-1:0]  tmo_limit,
    output logic [N_JOBS-1:0] job_go,
    input  logic [N_JOBS-1:0] job_done,
    output logic [N_JOBS-1:0] job_kill,
    output logic [N_JOBS-1:0] active,
    output logic              busy,
    output logic              join_done,
    output logic [N_JOBS-1:0] done_mask,
    output logic [ID_W-1:0]   first_id,
    output logic              timed_out,
    output logic              start_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_KILL   = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        M_ALL  = 2'd0,
        M_ANY  = 2'd1,
        M_NONE = 2'd2
    } mode_e;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic               kill_rest_q, kill_rest_d;
    logic [N_JOBS-1:0]  grp_q, grp_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [TMO_W-1:0]   timer_q, timer_d;
    logic [N_JOBS-1:0]  job_go_q, job_go_d;
    logic [N_JOBS-1:0]  active_q, active_d;
    logic               busy_q, busy_d;
    logic               join_done_q, join_done_d;
    logic [N_JOBS-1:0]  done_mask_q, done_mask_d;
    logic [ID_W-1:0]    first_id_q, first_id_d;
    logic               timed_out_q, timed_out_d;
    logic               start_err_q, start_err_d;

    logic [N_JOBS-1:0]  eff_done_c;
    logic [N_JOBS-1:0]  grp_done_c;
    logic [N_JOBS-1:0]  kill_c;
    logic [ID_W-1:0]    first_c;
    logic               tmo_hit_c;

    // Dones only count for jobs that are actually running.
    assign eff_done_c = job_done & active_q;
    assign grp_done_c = eff_done_c & grp_q;
    assign tmo_hit_c  = (tmo_q != '0) && (timer_q == tmo_q - TMO_W'(1));

    // The abort must spare a job that completes in the very same cycle, so it follows job_done.
    assign kill_c = (state_q == S_KILL) ? (active_q & grp_q & ~job_done) : '0;

    always_comb begin
        first_c = '0;
        for (int i = int'(N_JOBS) - 1; i >= 0; i--) begin
            if (grp_done_c[i]) first_c = ID_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        kill_rest_d = kill_rest_q;
        grp_d       = grp_q;
        tmo_d       = tmo_q;
        timer_d     = timer_q;
        job_go_d    = '0;
        active_d    = active_q & ~eff_done_c;
        done_mask_d = done_mask_q | grp_done_c;
        first_id_d  = first_id_q;
        timed_out_d = timed_out_q;
        join_done_d = 1'b0;
        start_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((job_mask != '0) && ((job_mask & active_q) == '0)) begin
                        case (mode)
                            2'b01:   mode_d = M_ANY;
                            2'b10:   mode_d = M_NONE;
                            default: mode_d = M_ALL;
                        endcase
                        kill_rest_d = kill_rest;
                        grp_d       = job_mask;
                        tmo_d       = tmo_limit;
                        timer_d     = '0;
                        done_mask_d = '0;
                        timed_out_d = 1'b0;
                        first_id_d  = '0;
                        job_go_d    = job_mask;
                        active_d    = active_d | job_mask;
                        state_d     = S_LAUNCH;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                if (mode_q == M_NONE) begin
                    state_d     = S_FINISH;
                    join_done_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (timer_q != '1) timer_d = timer_q + TMO_W'(1);
                // A completion resolving the join outranks a simultaneous timeout.
                if ((mode_q == M_ALL) && ((active_d & grp_q) == '0)) begin
                    state_d     = S_FINISH;
                    join_done_d = 1'b1;
                end else if ((mode_q == M_ANY) && (grp_done_c != '0)) begin
                    first_id_d = first_c;
                    if (kill_rest_q) begin
                        state_d = S_KILL;
                    end else begin
                        state_d     = S_FINISH;
                        join_done_d = 1'b1;
                    end
                end else if (tmo_hit_c) begin
                    timed_out_d = 1'b1;
                    state_d     = S_KILL;
                end
            end
            S_KILL: begin
                active_d    = active_d & ~kill_c;
                state_d     = S_FINISH;
                join_done_d = 1'b1;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= M_ALL;
            kill_rest_q <= 1'b0;
            grp_q       <= '0;
            tmo_q       <= '0;
            timer_q     <= '0;
            job_go_q    <= '0;
            active_q    <= '0;
            busy_q      <= 1'b0;
            join_done_q <= 1'b0;
            done_mask_q <= '0;
            first_id_q  <= '0;
            timed_out_q <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            kill_rest_q <= kill_rest_d;
            grp_q       <= grp_d;
            tmo_q       <= tmo_d;
            timer_q     <= timer_d;
            job_go_q    <= job_go_d;
            active_q    <= active_d;
            busy_q      <= busy_d;
            join_done_q <= join_done_d;
            done_mask_q <= done_mask_d;
            first_id_q  <= first_id_d;
            timed_out_q <= timed_out_d;
            start_err_q <= start_err_d;
        end
    end

    assign job_go    = job_go_q;
    assign job_kill  = kill_c;
    assign active    = active_q;
    assign busy      = busy_q;
    assign join_done = join_done_q;
    assign done_mask = done_mask_q;
    assign first_id  = first_id_q;
    assign timed_out = timed_out_q;
    assign start_err = start_err_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Scenario bench for fork_join_ctrl: expected join results are queued at launch and
// matched against join_done events captured by a monitor.
module tb_fork_join_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          kill_rest;
    logic [N-1:0]  job_mask;
    logic [TW-1:0] tmo_limit;
    logic [N-1:0]  job_go;
    logic [N-1:0]  job_done;
    logic [N-1:0]  job_kill;
    logic [N-1:0]  active;
    logic          busy;
    logic          join_done;
    logic [N-1:0]  done_mask;
    logic [1:0]    first_id;
    logic          timed_out;
    logic          start_err;

    fork_join_ctrl #(.N_JOBS(N), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .kill_rest(kill_rest),
        .job_mask(job_mask), .tmo_limit(tmo_limit), .job_go(job_go), .job_done(job_done),
        .job_kill(job_kill), .active(active), .busy(busy), .join_done(join_done),
        .done_mask(done_mask), .first_id(first_id), .timed_out(timed_out),
        .start_err(start_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  dm;
        logic [1:0]  fid;
        logic        to;
        logic [31:0] at;
    } join_t;

    join_t       exp_q[$];
    join_t       obs_q[$];
    int          obs_rd = 0;
    logic [31:0] cyc = 0;
    int          kill_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every join resolution and count cycles with an abort pulse.
    always @(negedge clk) begin
        if (join_done) obs_q.push_back('{dm: done_mask, fid: first_id, to: timed_out, at: cyc});
        if (job_kill != '0) kill_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] m, input logic k, input logic [3:0] msk,
                          input logic [15:0] tmo);
        start = 1'b1; mode = m; kill_rest = k; job_mask = msk; tmo_limit = tmo;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({job_go, job_kill, active, busy, join_done, done_mask, first_id, timed_out, start_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got go=%b kill=%b act=%b busy=%b jd=%b dm=%b fid=%0d to=%b se=%b, want all 0",
                     job_go, job_kill, active, busy, join_done, done_mask, first_id, timed_out, start_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_join_all;
        logic [31:0] s; int k0; join_t e, o;
        s = cyc; k0 = kill_cnt;
        launch(2'b00, 1'b0, 4'b0011, 16'd0);
        exp_q.push_back('{dm: 4'b0011, fid: 2'd0, to: 1'b0, at: s + 6});
        tick(); start = 1'b0;
        n_checks++;
        if (job_go !== 4'b0011 || active !== 4'b0011 || busy !== 1'b1) begin
            n_fail++; $display("FAIL all_launch: go=%b act=%b busy=%b, want 0011 0011 1", job_go, active, busy);
        end
        start = 1'b1; job_mask = 4'b1100;
        tick(); start = 1'b0;
        n_checks++;
        if (start_err !== 1'b0 || job_go !== 4'b0000) begin
            n_fail++; $display("FAIL busy_start_ignored: se=%b go=%b, want 0 0000", start_err, job_go);
        end
        tick(); job_done = 4'b0001;
        tick(); job_done = 4'b0000;
        n_checks++;
        if (active !== 4'b0010) begin
            n_fail++; $display("FAIL all_partial_active: got %b want 0010", active);
        end
        tick(); job_done = 4'b0010;
        tick(); job_done = 4'b0000;
        n_checks++;
        if (join_done !== 1'b1 || done_mask !== 4'b0011) begin
            n_fail++; $display("FAIL all_join: jd=%b dm=%b, want 1 0011", join_done, done_mask);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || active !== 4'b0000 || kill_cnt != k0) begin
            n_fail++; $display("FAIL all_after: busy=%b act=%b kills=%0d, want 0 0000 0", busy, active, kill_cnt - k0);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (obs_rd >= obs_q.size()) begin
            n_fail++; $display("FAIL sb_all: no join observed, want one at cycle %0d", e.at);
        end else begin
            o = obs_q[obs_rd]; obs_rd++;
            if (o !== e) begin
                n_fail++; $display("FAIL sb_all: got dm=%b fid=%0d to=%b at=%0d, want dm=%b fid=%0d to=%b at=%0d",
                                   o.dm, o.fid, o.to, o.at, e.dm, e.fid, e.to, e.at);
            end
        end
    endtask

    task automatic test_any_kill;
        logic [31:0] s; int k0; join_t e, o;
        s = cyc; k0 = kill_cnt;
        launch(2'b01, 1'b1, 4'b1111, 16'd0);
        exp_q.push_back('{dm: 4'b0100, fid: 2'd2, to: 1'b0, at: s + 4});
        tick(); start = 1'b0;
        n_checks++;
        if (job_go !== 4'b1111) begin
            n_fail++; $display("FAIL any_kill_go: got %b want 1111", job_go);
        end
        tick(); job_done = 4'b0100;
        tick(); job_done = 4'b0000;
        n_checks++;
        if (first_id !== 2'd2 || job_kill !== 4'b1011 || active !== 4'b1011) begin
            n_fail++; $display("FAIL any_kill_pulse: fid=%0d kill=%b act=%b, want 2 1011 1011", first_id, job_kill, active);
        end
        tick();
        n_checks++;
        if (join_done !== 1'b1 || active !== 4'b0000 || kill_cnt != k0 + 1) begin
            n_fail++; $display("FAIL any_kill_join: jd=%b act=%b kills=%0d, want 1 0000 1", join_done, active, kill_cnt - k0);
        end
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (obs_rd >= obs_q.size()) begin
            n_fail++; $display("FAIL sb_any_kill: no join observed, want one at cycle %0d", e.at);
        end else begin
            o = obs_q[obs_rd]; obs_rd++;
            if (o !== e) begin
                n_fail++; $display("FAIL sb_any_kill: got dm=%b fid=%0d to=%b at=%0d, want dm=%b fid=%0d to=%b at=%0d",
                                   o.dm, o.fid, o.to, o.at, e.dm, e.fid, e.to, e.at);
            end
        end
    endtask

    task automatic test_any_nokill_overlap;
        logic [31:0] s; join_t e, o;
        s = cyc;
        launch(2'b01, 1'b0, 4'b0110, 16'd0);
        exp_q.push_back('{dm: 4'b0010, fid: 2'd1, to: 1'b0, at: s + 3});
        tick(); start = 1'b0;
        tick(); job_done = 4'b0010;
        tick(); job_done = 4'b0000;
        n_checks++;
        if (join_done !== 1'b1 || active !== 4'b0100) begin
            n_fail++; $display("FAIL any_nokill_join: jd=%b act=%b, want 1 0100", join_done, active);
        end
        tick();
        launch(2'b00, 1'b0, 4'b0100, 16'd0);
        tick();
        n_checks++;
        if (start_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL overlap_reject: se=%b busy=%b, want 1 0", start_err, busy);
        end
        launch(2'b10, 1'b0, 4'b1000, 16'd0);
        exp_q.push_back('{dm: 4'b0000, fid: 2'd0, to: 1'b0, at: s + 7});
        tick(); start = 1'b0;
        n_checks++;
        if (job_go !== 4'b1000 || start_err !== 1'b0) begin
            n_fail++; $display("FAIL disjoint_accept: go=%b se=%b, want 1000 0", job_go, start_err);
        end
        tick(); tick();
        n_checks++;
        if (active !== 4'b1100 || busy !== 1'b0) begin
            n_fail++; $display("FAIL leftover_active: act=%b busy=%b, want 1100 0", active, busy);
        end
        job_done = 4'b1100;
        tick(); job_done = 4'b0000;
        n_checks++;
        if (active !== 4'b0000) begin
            n_fail++; $display("FAIL leftover_drain: got %b want 0000", active);
        end
        for (int j = 0; j < 2; j++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++; $display("FAIL sb_any_nokill: no join observed, want one at cycle %0d", e.at);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o !== e) begin
                    n_fail++; $display("FAIL sb_any_nokill: got dm=%b fid=%0d to=%b at=%0d, want dm=%b fid=%0d to=%b at=%0d",
                                       o.dm, o.fid, o.to, o.at, e.dm, e.fid, e.to, e.at);
                end
            end
        end
    endtask

    task automatic test_join_none;
        logic [31:0] s; join_t e, o;
        s = cyc;
        launch(2'b10, 1'b0, 4'b1001, 16'd0);
        exp_q.push_back('{dm: 4'b0000, fid: 2'd0, to: 1'b0, at: s + 2});
        tick(); start = 1'b0;
        n_checks++;
        if (job_go !== 4'b1001) begin
            n_fail++; $display("FAIL none_go: got %b want 1001", job_go);
        end
        tick();
        n_checks++;
        if (join_done !== 1'b1) begin
            n_fail++; $display("FAIL none_join: got %b want 1", join_done);
        end
        tick();
        n_checks++;
        if (active !== 4'b1001 || busy !== 1'b0) begin
            n_fail++; $display("FAIL none_active: act=%b busy=%b, want 1001 0", active, busy);
        end
        job_done = 4'b1001;
        tick(); job_done = 4'b0000;
        n_checks++;
        if (active !== 4'b0000) begin
            n_fail++; $display("FAIL none_drain: got %b want 0000", active);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (obs_rd >= obs_q.size()) begin
            n_fail++; $display("FAIL sb_none: no join observed, want one at cycle %0d", e.at);
        end else begin
            o = obs_q[obs_rd]; obs_rd++;
            if (o !== e) begin
                n_fail++; $display("FAIL sb_none: got dm=%b fid=%0d to=%b at=%0d, want dm=%b fid=%0d to=%b at=%0d",
                                   o.dm, o.fid, o.to, o.at, e.dm, e.fid, e.to, e.at);
            end
        end
    endtask

    task automatic test_timeout;
        logic [31:0] s; int k0; join_t e, o;
        // Four WAIT cycles with no completion: abort.
        s = cyc; k0 = kill_cnt;
        launch(2'b00, 1'b0, 4'b0011, 16'd4);
        exp_q.push_back('{dm: 4'b0000, fid: 2'd0, to: 1'b1, at: s + 7});
        tick(); start = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (job_kill !== 4'b0011 || active !== 4'b0011) begin
            n_fail++; $display("FAIL tmo_kill: kill=%b act=%b, want 0011 0011", job_kill, active);
        end
        tick();
        n_checks++;
        if (join_done !== 1'b1 || timed_out !== 1'b1 || active !== 4'b0000) begin
            n_fail++; $display("FAIL tmo_join: jd=%b to=%b act=%b, want 1 1 0000", join_done, timed_out, active);
        end
        tick();
        // Completion lands on the timeout cycle: the join wins.
        s = cyc; k0 = kill_cnt;
        launch(2'b00, 1'b0, 4'b0011, 16'd4);
        exp_q.push_back('{dm: 4'b0011, fid: 2'd0, to: 1'b0, at: s + 6});
        tick(); start = 1'b0;
        repeat (4) tick();
        job_done = 4'b0011;
        tick(); job_done = 4'b0000;
        n_checks++;
        if (join_done !== 1'b1 || timed_out !== 1'b0 || kill_cnt != k0) begin
            n_fail++; $display("FAIL tmo_race: jd=%b to=%b kills=%0d, want 1 0 0", join_done, timed_out, kill_cnt - k0);
        end
        tick();
        for (int j = 0; j < 2; j++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++; $display("FAIL sb_timeout: no join observed, want one at cycle %0d", e.at);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o !== e) begin
                    n_fail++; $display("FAIL sb_timeout: got dm=%b fid=%0d to=%b at=%0d, want dm=%b fid=%0d to=%b at=%0d",
                                       o.dm, o.fid, o.to, o.at, e.dm, e.fid, e.to, e.at);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int k0;
        k0 = kill_cnt;
        launch(2'b00, 1'b0, 4'b0111, 16'd0);
        tick(); start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1 || active !== 4'b0111) begin
            n_fail++; $display("FAIL mid_pre: busy=%b act=%b, want 1 0111", busy, active);
        end
        rst = 1'b1;
        tick(); rst = 1'b0;
        n_checks++;
        if ({job_go, job_kill, active, busy, join_done, done_mask, first_id, timed_out, start_err} !== '0
            || kill_cnt != k0) begin
            n_fail++; $display("FAIL mid_reset: go=%b kill=%b act=%b busy=%b jd=%b kills=%0d, want all 0",
                               job_go, job_kill, active, busy, join_done, kill_cnt - k0);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'b00; kill_rest = 1'b0;
        job_mask = '0; tmo_limit = '0; job_done = '0;
        test_reset();
        test_join_all();
        test_any_kill();
        test_any_nokill_overlap();
        test_join_none();
        test_timeout();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0 || obs_rd != obs_q.size()) begin
            n_fail++; $display("FAIL sb_drain: pending expected=%0d unmatched joins=%0d, want 0 0",
                               exp_q.size(), obs_q.size() - obs_rd);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
